frame_sync: RTL and testbench
=============================

# frame_sync

Serial frame synchronizer that consumes the recovered bitstream from the transmitter/receiver chain (`decoder_out` qualified by a valid strobe). It hunts for a fixed sync word and confirms frame alignment over consecutive frames. Once locked, it emits payload bytes with a flywheel tolerance for corrupted sync words. It sits directly downstream of the decoder and feeds byte-level data and lock/error status to the experiment's display and BER logic.

## Interface
- SYNC_WORD, 8'hB8, sync pattern, MSB received first; must be nonzero
- PAYLOAD_BYTES, 4, payload bytes per frame (1..15)
- LOCK_CNT, 2, consecutive good sync words required to declare lock (1..7)
- MISS_CNT, 2, consecutive bad sync words while locked that force loss of lock (1..7)

- sys_clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- bit_in  in  1  serial data bit (decoder output)
- bit_valid  in  1  bit_in is sampled on this edge; when low, all state holds
- data_out  out  8  last assembled payload byte, MSB = first received bit
- data_valid  out  1  one-cycle pulse; data_out is new
- frame_start  out  1  high together with data_valid for byte 0 of each frame
- locked  out  1  frame alignment confirmed
- sync_err_cnt  out  8  saturating count of bad sync words seen while locked

## Operation
- Frame format: 8 sync bits, then PAYLOAD_BYTES×8 payload bits, MSB first. Frame length is F = 8 + 8·PAYLOAD_BYTES bits (40 by default).
- Shift register sr[7:0] shifts left on every valid bit: sr ← {sr[6:0], bit_in}. A fill counter saturates at 8. No sync compare is made before 8 bits have been received since reset.
- State HUNT:
  - Each valid bit, compare the updated sr with SYNC_WORD.
  - On a match: go to VERIFY, hit_cnt = 1, bit_cnt = 0.
  - If LOCK_CNT = 1, go straight to LOCKED instead.
- State VERIFY:
  - bit_cnt counts the valid bits received since the last sync; payload bits are discarded.
  - When bit_cnt reaches F, compare the updated sr with SYNC_WORD.
  - On a match: increment hit_cnt and reset bit_cnt to 0. When hit_cnt reaches LOCK_CNT, go to LOCKED with miss_cnt = 0.
  - On a mismatch: go to HUNT. The failing window is not re-tested as a new sync candidate; hunting resumes with the next bit.
- State LOCKED:
  - locked = 1.
  - After every 8th payload bit, register data_out = sr and pulse data_valid. frame_start accompanies byte 0.
  - At each sync position, compare sr with SYNC_WORD. On a match, set miss_cnt = 0.
  - On a mismatch:
    - increment sync_err_cnt, saturating at 255;
    - increment miss_cnt;
    - if miss_cnt reaches MISS_CNT, go to HUNT and clear locked;
    - otherwise stay LOCKED (flywheel) and keep outputting the next frame's payload.
- sync_err_cnt is cleared only by reset. It is not cleared on relock.
- Reset (asynchronous, any time, mid-frame included) forces HUNT and clears sr, the fill counter, bit_cnt, hit_cnt and miss_cnt.

## Timing
- All outputs are registered. They are updated on the same rising edge that samples the qualifying valid bit and are visible in the following cycle.
- Reset values: data_out = 0, data_valid = 0, frame_start = 0, locked = 0, sync_err_cnt = 0.
- Byte latency: data_valid is high during the cycle after the edge that samples the byte's 8th bit.
- locked timing:
  - Rises on the edge sampling the last bit of the LOCK_CNT-th consecutive good sync.
  - Falls on the edge sampling the last bit of the MISS_CNT-th consecutive bad sync.
- With bit_valid low, no counter advances and data_valid/frame_start are 0. Gaps of any length are transparent to alignment.
- data_valid is never high for two consecutive cycles unless bit_valid is high continuously and a byte boundary recurs. With PAYLOAD_BYTES ≥ 1 this cannot happen, because a byte needs 8 valid bits.

## Test plan
- Default parameters, bit_valid held high, frames sync=B8 with payload 01 23 45 67 repeated:
  - locked rises after the 48th bit (second sync);
  - the first data_valid follows bit 56 with data_out = 01 and frame_start = 1;
  - next bytes are 23, 45, 67, then frame_start again on the following 01.
- Locked, one frame's sync corrupted to B9:
  - locked stays 1 and sync_err_cnt = 1;
  - that frame's payload is still output;
  - the next good sync resets miss_cnt.
- Locked, two consecutive syncs corrupted: locked falls after the second bad sync; sync_err_cnt = 2; no data_valid until lock is re-acquired.
- A false B8 inside random preamble bits, followed by no sync F bits later: the FSM returns to HUNT; the true frames that follow still reach lock after 2 syncs.
- bit_valid toggled 1-0-1-0 over the default stream: same byte sequence as the first scenario; data_valid occurs only after valid bits.
- Reset pulsed low mid-payload while locked: all outputs return to reset values immediately; re-lock takes two fresh syncs; sync_err_cnt = 0.

Source files
------------

// File: rtl/frame_sync_if.sv
// -----------------------------------------------------------------------------
// frame_sync_if
// Groups the bit-level input stream and the byte/status outputs of the frame
// synchronizer into one bundle.
//
//   bit_in        serial data bit from the decoder
//   bit_valid     bit_in qualifier; the synchronizer samples only when high
//   data_out      last assembled payload byte, MSB = first received bit
//   data_valid    one-cycle pulse, data_out is new
//   frame_start   accompanies data_valid on byte 0 of each frame
//   locked        frame alignment confirmed
//   sync_err_cnt  saturating count of bad sync words seen while locked
//
// Modports:
//   master  bit source / status consumer (decoder side, testbench)
//   slave   the synchronizer itself
// -----------------------------------------------------------------------------
interface frame_sync_if;
    logic       bit_in;
    logic       bit_valid;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_start;
    logic       locked;
    logic [7:0] sync_err_cnt;

    modport master (
        output bit_in,
        output bit_valid,
        input  data_out,
        input  data_valid,
        input  frame_start,
        input  locked,
        input  sync_err_cnt
    );

    modport slave (
        input  bit_in,
        input  bit_valid,
        output data_out,
        output data_valid,
        output frame_start,
        output locked,
        output sync_err_cnt
    );
endinterface

// File: rtl/frame_sync.sv
// -----------------------------------------------------------------------------
// frame_sync
// Serial frame synchronizer. Hunts for SYNC_WORD in the valid-qualified bit
// stream, confirms alignment over LOCK_CNT consecutive frames, then emits the
// payload bytes of every frame. While locked, up to MISS_CNT-1 consecutive bad
// sync words are tolerated (flywheel); each bad sync while locked is counted.
//
// Frame: 8 sync bits followed by PAYLOAD_BYTES*8 payload bits, MSB first.
//
// Ports:
//   sys_clk  system clock, rising edge
//   reset    asynchronous, active-low reset
//   fs       frame_sync_if.slave: bit_in/bit_valid in; data_out, data_valid,
//            frame_start, locked, sync_err_cnt out (all registered)
// -----------------------------------------------------------------------------
module frame_sync #(
    parameter logic [7:0] SYNC_WORD     = 8'hB8,
    parameter int         PAYLOAD_BYTES = 4,
    parameter int         LOCK_CNT      = 2,
    parameter int         MISS_CNT      = 2
) (
    input  logic        sys_clk,
    input  logic        reset,
    frame_sync_if.slave fs
);
    localparam logic [7:0] FRAME_BITS   = 8'(8 + 8 * PAYLOAD_BYTES);
    localparam logic [7:0] PAYLOAD_BITS = 8'(8 * PAYLOAD_BYTES);
    localparam logic [2:0] LOCK_TGT     = 3'(LOCK_CNT);
    localparam logic [2:0] MISS_TGT     = 3'(MISS_CNT);

    typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

    state_t     state, state_n;
    logic [7:0] sr, sr_n;
    logic [3:0] fill, fill_n;
    logic [7:0] bit_cnt, bit_cnt_n, bit_cnt_inc;
    logic [2:0] hit_cnt, hit_n;
    logic [2:0] miss_cnt, miss_n;
    logic [7:0] err_cnt, err_n;
    logic [7:0] dout, dout_n;
    logic       dv, dv_n;
    logic       fst, fst_n;
    logic       lk, lk_n;
    logic       sync_hit;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            state    <= HUNT;
            sr       <= '0;
            fill     <= '0;
            bit_cnt  <= '0;
            hit_cnt  <= '0;
            miss_cnt <= '0;
            err_cnt  <= '0;
            dout     <= '0;
            dv       <= 1'b0;
            fst      <= 1'b0;
            lk       <= 1'b0;
        end else begin
            state    <= state_n;
            sr       <= sr_n;
            fill     <= fill_n;
            bit_cnt  <= bit_cnt_n;
            hit_cnt  <= hit_n;
            miss_cnt <= miss_n;
            err_cnt  <= err_n;
            dout     <= dout_n;
            dv       <= dv_n;
            fst      <= fst_n;
            lk       <= lk_n;
        end
    end

    always_comb begin
        state_n     = state;
        sr_n        = sr;
        fill_n      = fill;
        bit_cnt_n   = bit_cnt;
        hit_n       = hit_cnt;
        miss_n      = miss_cnt;
        err_n       = err_cnt;
        dout_n      = dout;
        dv_n        = 1'b0;
        fst_n       = 1'b0;
        bit_cnt_inc = bit_cnt + 8'd1;
        sync_hit    = 1'b0;

        if (fs.bit_valid) begin
            sr_n = {sr[6:0], fs.bit_in};
            if (fill != 4'd8) fill_n = fill + 4'd1;
            sync_hit = (sr_n == SYNC_WORD);

            case (state)
                HUNT: begin
                    // Only a full window of real bits may match.
                    if (fill_n == 4'd8 && sync_hit) begin
                        bit_cnt_n = '0;
                        hit_n     = 3'd1;
                        miss_n    = '0;
                        state_n   = (LOCK_CNT == 1) ? LOCKED : VERIFY;
                    end
                end

                VERIFY: begin
                    bit_cnt_n = bit_cnt_inc;
                    if (bit_cnt_inc == FRAME_BITS) begin
                        bit_cnt_n = '0;
                        if (sync_hit) begin
                            hit_n = hit_cnt + 3'd1;
                            if (hit_n == LOCK_TGT) begin
                                state_n = LOCKED;
                                miss_n  = '0;
                            end
                        end else begin
                            // The failing window is not re-tested; HUNT
                            // resumes with the next bit.
                            state_n = HUNT;
                        end
                    end
                end

                LOCKED: begin
                    bit_cnt_n = bit_cnt_inc;
                    if (bit_cnt_inc <= PAYLOAD_BITS && bit_cnt_inc[2:0] == 3'd0) begin
                        dout_n = sr_n;
                        dv_n   = 1'b1;
                        fst_n  = (bit_cnt_inc == 8'd8);
                    end
                    if (bit_cnt_inc == FRAME_BITS) begin
                        // Alignment is kept on a bad sync (flywheel) until
                        // MISS_CNT consecutive misses.
                        bit_cnt_n = '0;
                        if (sync_hit) begin
                            miss_n = '0;
                        end else begin
                            err_n  = sat_inc8(err_cnt);
                            miss_n = miss_cnt + 3'd1;
                            if (miss_n == MISS_TGT) state_n = HUNT;
                        end
                    end
                end

                default: state_n = HUNT;
            endcase
        end

        lk_n = (state_n == LOCKED);
    end

    assign fs.data_out     = dout;
    assign fs.data_valid   = dv;
    assign fs.frame_start  = fst;
    assign fs.locked       = lk;
    assign fs.sync_err_cnt = err_cnt;
endmodule

// File: tb/tb_frame_sync.sv
// -----------------------------------------------------------------------------
// tb_frame_sync
// Randomized self-checking bench for frame_sync. Each segment builds a bit
// stream, derives the expected per-bit outputs from a frame-level reference
// model (window scans at frame offsets), then drives the stream with a chosen
// bit_valid pattern and compares every cycle.
// -----------------------------------------------------------------------------
module tb_frame_sync;
    localparam logic [7:0] SYNC   = 8'hB8;
    localparam int         P      = 4;
    localparam int         F      = 8 + 8 * P;
    localparam int         LOCK_N = 2;
    localparam int         MISS_N = 2;
    localparam logic [8*P-1:0] DEF_PL = 32'h01234567;

    logic sys_clk = 1'b0;
    logic reset   = 1'b1;

    frame_sync_if fsif ();

    frame_sync #(
        .SYNC_WORD    (SYNC),
        .PAYLOAD_BYTES(P),
        .LOCK_CNT     (LOCK_N),
        .MISS_CNT     (MISS_N)
    ) dut (
        .sys_clk(sys_clk),
        .reset  (reset),
        .fs     (fsif)
    );

    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_fail   = 0;

    bit         s_bits[$];
    bit         e_dv[];
    bit         e_fs[];
    bit         e_lk[];
    logic [7:0] e_dout[];
    int         e_err[];

    task automatic check_val(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, act, exp, $time);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) s_bits.push_back(b[i]);
    endtask

    task automatic push_frame(input logic [7:0] sw, input logic [8*P-1:0] pl);
        push_byte(sw);
        for (int j = P - 1; j >= 0; j--) push_byte(pl[8*j +: 8]);
    endtask

    function automatic logic [7:0] win(input int k);
        logic [7:0] w;
        for (int j = 0; j < 8; j++) w[7-j] = s_bits[k-7+j];
        return w;
    endfunction

    // Reference: scan for the sync word, then jump frame by frame.
    function automatic void compute_model();
        int n, k, anchor, hits, miss, err, nx, idx, cur_lk, cur_err;
        int lk_evt[];
        int err_evt[];
        bit done;
        n = s_bits.size();
        e_dv = new[n]; e_fs = new[n]; e_lk = new[n]; e_dout = new[n]; e_err = new[n];
        lk_evt = new[n]; err_evt = new[n];
        for (int i = 0; i < n; i++) begin
            e_dv[i] = 0; e_fs[i] = 0; e_dout[i] = '0; lk_evt[i] = -1; err_evt[i] = -1;
        end
        k = 7; err = 0; done = 0; anchor = 0; hits = 0; miss = 0;
        while (!done && k < n) begin
            if (win(k) != SYNC) begin
                k++;
                continue;
            end
            anchor = k; hits = 1;
            while (hits < LOCK_N) begin
                nx = anchor + F;
                if (nx >= n) begin done = 1; break; end
                if (win(nx) != SYNC) break;
                hits++;
                anchor = nx;
            end
            if (done) break;
            if (hits < LOCK_N) begin
                k = anchor + F + 1;
                continue;
            end
            lk_evt[anchor] = 1;
            miss = 0;
            while (1) begin
                for (int j = 1; j <= P; j++) begin
                    idx = anchor + 8 * j;
                    if (idx < n) begin
                        e_dv[idx] = 1; e_fs[idx] = (j == 1); e_dout[idx] = win(idx);
                    end
                end
                nx = anchor + F;
                if (nx >= n) begin done = 1; break; end
                if (win(nx) == SYNC) begin
                    miss = 0;
                end else begin
                    if (err < 255) err++;
                    err_evt[nx] = err;
                    miss++;
                    if (miss >= MISS_N) begin
                        lk_evt[nx] = 0;
                        k = nx + 1;
                        break;
                    end
                end
                anchor = nx;
            end
        end
        cur_lk = 0; cur_err = 0;
        for (int i = 0; i < n; i++) begin
            if (lk_evt[i] >= 0) cur_lk = lk_evt[i];
            if (err_evt[i] >= 0) cur_err = err_evt[i];
            e_lk[i]  = (cur_lk != 0);
            e_err[i] = cur_err;
        end
    endfunction

    task automatic apply_reset(input bit check_outs);
        @(posedge sys_clk);
        #2;
        reset = 1'b0;
        fsif.bit_valid = 1'b0;
        fsif.bit_in    = 1'b0;
        #1;
        if (check_outs) begin
            check_val("rst data_valid",   int'(fsif.data_valid),   0);
            check_val("rst frame_start",  int'(fsif.frame_start),  0);
            check_val("rst locked",       int'(fsif.locked),       0);
            check_val("rst data_out",     int'(fsif.data_out),     0);
            check_val("rst sync_err_cnt", int'(fsif.sync_err_cnt), 0);
        end
        repeat (2) @(negedge sys_clk);
        reset = 1'b1;
    endtask

    // vmode: 0 = always valid, 1 = toggle 1-0-1-0, 2 = random (~2/3 valid)
    task automatic run_segment(input int vmode, input bit chk_first);
        int n, k, cyc, last, pk;
        int first_lock, first_dv, first_byte;
        bit pv, v;
        compute_model();
        n = s_bits.size();
        k = 0; cyc = 0; last = -1; pk = 0; pv = 0;
        first_lock = -1; first_dv = -1; first_byte = -1;
        while (1) begin
            @(negedge sys_clk);
            if (pv) begin
                check_val("data_valid",  int'(fsif.data_valid),  int'(e_dv[pk]));
                check_val("frame_start", int'(fsif.frame_start), int'(e_fs[pk]));
                if (e_dv[pk]) check_val("data_out", int'(fsif.data_out), int'(e_dout[pk]));
            end else begin
                check_val("idle data_valid",  int'(fsif.data_valid),  0);
                check_val("idle frame_start", int'(fsif.frame_start), 0);
            end
            check_val("locked",       int'(fsif.locked),       (last >= 0) ? int'(e_lk[last]) : 0);
            check_val("sync_err_cnt", int'(fsif.sync_err_cnt), (last >= 0) ? e_err[last] : 0);
            if (chk_first) begin
                if (first_lock < 0 && fsif.locked === 1'b1) first_lock = last + 1;
                if (first_dv < 0 && fsif.data_valid === 1'b1) begin
                    first_dv   = last + 1;
                    first_byte = int'(fsif.data_out);
                end
            end
            if (k >= n) break;
            if (cyc > 4 * n + 100) begin
                check_val("segment timeout bits", k, n);
                break;
            end
            case (vmode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = ($urandom_range(0, 2) != 0);
            endcase
            fsif.bit_valid = v;
            fsif.bit_in    = v ? s_bits[k] : 1'($urandom_range(0, 1));
            pv = v;
            pk = k;
            if (v) begin
                last = k;
                k++;
            end
            cyc++;
        end
        fsif.bit_valid = 1'b0;
        if (chk_first) begin
            check_val("first lock bit", first_lock, 48);
            check_val("first byte bit", first_dv,   56);
            check_val("first byte",     first_byte, 1);
        end
    endtask

    initial begin
        logic [7:0]     sw;
        logic [7:0]     sync_v;
        logic [8*P-1:0] pl;
        fsif.bit_valid = 1'b0;
        fsif.bit_in    = 1'b0;
        sync_v         = SYNC;

        apply_reset(1);

        // Clean default stream, ending mid-payload while locked.
        s_bits.delete();
        repeat (6) push_frame(SYNC, DEF_PL);
        push_byte(SYNC); push_byte(8'h01);
        for (int i = 0; i < 4; i++) s_bits.push_back(i[0]);
        run_segment(0, 1);
        apply_reset(1);

        // Fresh relock after reset; one corrupted sync while locked.
        s_bits.delete();
        for (int f = 0; f < 8; f++) push_frame((f == 3) ? 8'hB9 : SYNC, DEF_PL);
        run_segment(0, 1);
        apply_reset(1);

        // Two consecutive corrupted syncs, then relock; random gaps.
        s_bits.delete();
        for (int f = 0; f < 10; f++) push_frame((f == 3 || f == 4) ? 8'hB9 : SYNC, DEF_PL);
        run_segment(2, 0);
        apply_reset(1);

        // False sync word inside a random preamble.
        s_bits.delete();
        for (int i = 0; i < 20; i++) s_bits.push_back(1'($urandom_range(0, 1)));
        for (int i = 0; i < 8; i++) s_bits[3+i] = sync_v[7-i];
        repeat (5) push_frame(SYNC, DEF_PL);
        run_segment(2, 0);
        apply_reset(1);

        // Default stream with bit_valid toggling.
        s_bits.delete();
        repeat (6) push_frame(SYNC, DEF_PL);
        run_segment(1, 1);
        apply_reset(1);

        // Random payloads, random sync corruption, random preamble and gaps.
        s_bits.delete();
        for (int i = 0; i < int'($urandom_range(0, 30)); i++) s_bits.push_back(1'($urandom_range(0, 1)));
        for (int f = 0; f < 40; f++) begin
            sw = SYNC;
            if ($urandom_range(0, 3) == 0) sw = SYNC ^ (8'h01 << $urandom_range(0, 7));
            pl = $urandom;
            push_frame(sw, pl);
        end
        run_segment(2, 0);
        apply_reset(1);

        // Alternating bad/good syncs while locked to saturate the error count.
        s_bits.delete();
        repeat (2) push_frame(SYNC, DEF_PL);
        repeat (270) begin
            push_frame(8'hB9, DEF_PL);
            push_frame(SYNC, DEF_PL);
        end
        run_segment(0, 0);
        check_val("sync_err_cnt saturated", int'(fsif.sync_err_cnt), 255);
        check_val("locked after flywheel run", int'(fsif.locked), 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
